// File: rtl/demux1x2_temporizado_if.sv
// Handshake/data bundle for the timed 1-to-2 demultiplexer.
// master: the producer that issues loads; slave: the demultiplexer itself.
interface demux1x2_temporizado_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             SEL;
  logic             load;
  logic             ready;
  logic [WIDTH-1:0] OUT0;
  logic [WIDTH-1:0] OUT1;
  logic             ativo0;
  logic             ativo1;
  logic             fim;

  modport master (
    output D, SEL, load,
    input  ready, OUT0, OUT1, ativo0, ativo1, fim
  );

  modport slave (
    input  D, SEL, load,
    output ready, OUT0, OUT1, ativo0, ativo1, fim
  );
endinterface

// File: rtl/demux1x2_temporizado.sv
// Registered 1-to-2 demultiplexer with a hold timer.
// A accepted load steers D to OUT0 or OUT1 (by SEL) for HOLD_CYCLES clocks,
// then both outputs clear and fim pulses for one cycle.
// Optional feature macro: DEMUX_RETRIGGER_EN -- when defined, a load during
// HOLD recaptures the value and restarts the hold window.
module demux1x2_temporizado #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  demux1x2_temporizado_if.slave  bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

`ifdef DEMUX_RETRIGGER_EN
  localparam logic HOLD_READY = 1'b1;
`else
  localparam logic HOLD_READY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, FIM} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out0_q;
  logic [WIDTH-1:0] out1_q;
  logic             ativo0_q;
  logic             ativo1_q;
  logic             fim_q;
  logic             ready_q;

  logic [WIDTH-1:0] cap0;
  logic [WIDTH-1:0] cap1;

  // Values captured on an accepted load: selected side gets D, the other is zero.
  always_comb begin
    cap0 = '0;
    cap1 = '0;
    if (bus.SEL) cap1 = bus.D;
    else         cap0 = bus.D;
  end

  // Control FSM with registered outputs; reset has priority over load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      ativo0_q <= 1'b0;
      ativo1_q <= 1'b0;
      fim_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          fim_q <= 1'b0;
          if (bus.load) begin
            out0_q   <= cap0;
            out1_q   <= cap1;
            ativo0_q <= ~bus.SEL;
            ativo1_q <= bus.SEL;
            cnt      <= '0;
            ready_q  <= HOLD_READY;
            state    <= HOLD;
          end
        end
        HOLD: begin
`ifdef DEMUX_RETRIGGER_EN
          // A retrigger beats expiry on the same edge.
          if (bus.load) begin
            out0_q   <= cap0;
            out1_q   <= cap1;
            ativo0_q <= ~bus.SEL;
            ativo1_q <= bus.SEL;
            cnt      <= '0;
          end else
`endif
          if (cnt == LAST) begin
            out0_q   <= '0;
            out1_q   <= '0;
            ativo0_q <= 1'b0;
            ativo1_q <= 1'b0;
            fim_q    <= 1'b1;
            ready_q  <= 1'b0;
            state    <= FIM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIM: begin
          fim_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          out0_q   <= '0;
          out1_q   <= '0;
          ativo0_q <= 1'b0;
          ativo1_q <= 1'b0;
          fim_q    <= 1'b0;
          ready_q  <= 1'b1;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.OUT0   = out0_q;
  assign bus.OUT1   = out1_q;
  assign bus.ativo0 = ativo0_q;
  assign bus.ativo1 = ativo1_q;
  assign bus.fim    = fim_q;
  assign bus.ready  = ready_q;

endmodule

// File: tb/tb_demux1x2_temporizado.sv
// Table-driven bench for demux1x2_temporizado (WIDTH=4, HOLD_CYCLES=4).
// Each row gives inputs applied before a rising edge and the outputs
// expected just after that edge.
module tb_demux1x2_temporizado;

  localparam int W = 4;

`ifdef DEMUX_RETRIGGER_EN
  localparam logic HR = 1'b1;
`else
  localparam logic HR = 1'b0;
`endif

  typedef struct {
    logic         rst;
    logic         ld;
    logic         sel;
    logic [W-1:0] d;
    logic         rdy;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic         a0;
    logic         a1;
    logic         fim;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nbad = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  demux1x2_temporizado_if #(.WIDTH(W)) bus ();

  demux1x2_temporizado #(.WIDTH(W), .HOLD_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic add(input logic rst, input logic ld, input logic sel, input logic [W-1:0] d,
                     input logic rdy, input logic [W-1:0] o0, input logic [W-1:0] o1,
                     input logic a0, input logic a1, input logic fim);
    vec_t v;
    v.rst = rst; v.ld = ld; v.sel = sel; v.d = d;
    v.rdy = rdy; v.o0 = o0; v.o1 = o1; v.a0 = a0; v.a1 = a1; v.fim = fim;
    tbl.push_back(v);
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clock);
    reset    = v.rst;
    bus.load = v.ld;
    bus.SEL  = v.sel;
    bus.D    = v.d;
    @(posedge clock);
    #1;
    nvec++;
    if ({bus.ready, bus.OUT0, bus.OUT1, bus.ativo0, bus.ativo1, bus.fim} !==
        {v.rdy, v.o0, v.o1, v.a0, v.a1, v.fim}) begin
      nbad++;
      $display("FAIL %s: got rdy=%b o0=%h o1=%h a=%b%b fim=%b, want rdy=%b o0=%h o1=%h a=%b%b fim=%b",
               name, bus.ready, bus.OUT0, bus.OUT1, bus.ativo0, bus.ativo1, bus.fim,
               v.rdy, v.o0, v.o1, v.a0, v.a1, v.fim);
    end
  endtask

  initial begin
    vec_t v;
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.SEL  = 1'b0;
    bus.D    = '0;

    // Reset with load=1 pending: reset wins.
    add(1, 1, 0, 4'hF, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 4'hF, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // Route A to OUT0: four hold cycles, fim, ready again.
    add(0, 1, 0, 4'hA, HR, 4'hA, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, HR, 4'hA, 0, 1, 0, 0);
    add(0, 0, 0, 4'h2, HR, 4'hA, 0, 1, 0, 0);
    add(0, 0, 1, 4'h3, HR, 4'hA, 0, 1, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // Route 5 to OUT1; D/SEL wiggle during hold has no effect.
    add(0, 1, 1, 4'h5, HR, 0, 4'h5, 0, 1, 0);
    add(0, 0, 0, 4'hF, HR, 0, 4'h5, 0, 1, 0);
    add(0, 0, 1, 4'h9, HR, 0, 4'h5, 0, 1, 0);
    add(0, 0, 0, 4'h6, HR, 0, 4'h5, 0, 1, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // Reset during the 2nd hold cycle: back to idle, no fim afterwards.
    add(0, 1, 0, 4'h7, HR, 4'h7, 0, 1, 0, 0);
    add(0, 0, 0, 4'h7, HR, 4'h7, 0, 1, 0, 0);
    add(1, 0, 0, 4'h7, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
`ifndef DEMUX_RETRIGGER_EN
    // Back-to-back: load held high, SEL alternating; one accept per 6 cycles.
    add(0, 1, 0, 4'h1, 0, 4'h1, 0, 1, 0, 0);
    add(0, 1, 1, 4'h2, 0, 4'h1, 0, 1, 0, 0);
    add(0, 1, 0, 4'h3, 0, 4'h1, 0, 1, 0, 0);
    add(0, 1, 1, 4'h4, 0, 4'h1, 0, 1, 0, 0);
    add(0, 1, 0, 4'h5, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4'h6, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 4'h7, 0, 0, 4'h7, 0, 1, 0);
    add(0, 1, 0, 4'h8, 0, 0, 4'h7, 0, 1, 0);
    add(0, 1, 1, 4'h9, 0, 0, 4'h7, 0, 1, 0);
    add(0, 1, 0, 4'hA, 0, 0, 4'h7, 0, 1, 0);
    add(0, 1, 1, 4'hB, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
`endif

    foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);

    // Busy load during the hold of 3 on OUT0.
    v = '{0, 1, 0, 4'h3, HR, 4'h3, 0, 1, 0, 0};
    step("busy_start", v);
`ifdef DEMUX_RETRIGGER_EN
    v = '{0, 1, 1, 4'hC, 1, 0, 4'hC, 0, 1, 0};
    step("busy_retrig", v);
    for (int i = 0; i < 3; i++) begin
      v = '{0, 0, 0, 4'h0, 1, 0, 4'hC, 0, 1, 0};
      step($sformatf("busy_hold%0d", i), v);
    end
`else
    v = '{0, 1, 1, 4'hC, 0, 4'h3, 0, 1, 0, 0};
    step("busy_ignored", v);
    for (int i = 0; i < 2; i++) begin
      v = '{0, 0, 0, 4'h0, 0, 4'h3, 0, 1, 0, 0};
      step($sformatf("busy_hold%0d", i), v);
    end
`endif
    v = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1};
    step("busy_fim", v);
    v = '{0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0};
    step("busy_idle", v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
